// File: rtl/mem_bus_pkg.sv
// Shared definitions for the external multiplexed memory pin bus: cycle
// phases, strobe idle level and the default address/data widths.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    LATCH = 3'd2,
    DATA  = 3'd3,
    RECOV = 3'd4
  } state_t;

  localparam logic STROBE_IDLE = 1'b1;

  localparam int ADR_W_DEF = 20;
  localparam int DAT_W_DEF = 16;

endpackage

// File: rtl/bus_rr_arbiter.sv
// Combinational requester selection: lowest index first, or a circular search
// starting just after the last winner. The pointer register lives in the parent.
module bus_rr_arbiter #(
  parameter int NCH = 3,
  parameter int IW  = 2
) (
  input  logic [NCH-1:0] i_req,
  input  logic [IW-1:0]  i_pointer,
  input  logic           i_mode,
  output logic [NCH-1:0] o_grant,
  output logic [IW-1:0]  o_index
);

  always_comb begin
    int   j;
    logic found;
    o_grant = '0;
    o_index = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NCH; k++) begin
      if (i_mode) begin
        j = int'(i_pointer) + 1 + k;
        if (j >= NCH) j = j - NCH;
      end else begin
        j = k;
      end
      if (!found && i_req[j]) begin
        found      = 1'b1;
        o_grant[j] = 1'b1;
        o_index    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates NCH requesters onto the shared multiplexed address/data pin bus,
// sequencing ALE/OE/WE strobes with programmable data-phase wait states.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int ADR_W = ADR_W_DEF,
  parameter int DAT_W = DAT_W_DEF,
  parameter int WAIT  = 1,
  parameter int RR    = 1,
  localparam int IW   = $clog2(NCH),
  localparam int HI_W = (ADR_W > DAT_W) ? (ADR_W - DAT_W) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NCH-1:0]         req,
  output logic [NCH-1:0]         ack,
  input  logic [NCH-1:0]         rw,
  input  logic [NCH-1:0]         io,
  input  logic [NCH*ADR_W-1:0]   adr,
  input  logic [NCH*DAT_W-1:0]   dtw,
  output logic [DAT_W-1:0]       dtr,
  input  logic [DAT_W-1:0]       din,
  output logic [DAT_W-1:0]       dout,
  output logic                   isout,
  output logic [HI_W-1:0]        adr_hi,
  output logic                   ale_n,
  output logic                   oe_n,
  output logic                   we_n,
  output logic                   pio,
  output logic                   busy
);

  state_t           r_state, w_state_next;
  logic [IW-1:0]    r_ptr, r_idx, w_idx;
  logic [NCH-1:0]   w_grant;
  logic             w_any;
  logic [ADR_W-1:0] r_adr;
  logic             r_rw, r_io;
  logic [DAT_W-1:0] r_dtw, r_dtr;
  logic [3:0]       r_cnt;
  logic [ADR_W-1:0] w_adr_ch [NCH];
  logic [DAT_W-1:0] w_dtw_ch [NCH];

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign w_adr_ch[gi] = adr[gi*ADR_W +: ADR_W];
      assign w_dtw_ch[gi] = dtw[gi*DAT_W +: DAT_W];
      assign ack[gi]      = (r_state == RECOV) && (r_idx == IW'(gi));
    end
  endgenerate

  bus_rr_arbiter #(
    .NCH (NCH),
    .IW  (IW)
  ) u_arb (
    .i_req     (req),
    .i_pointer (r_ptr),
    .i_mode    (RR != 0),
    .o_grant   (w_grant),
    .o_index   (w_idx)
  );

  assign w_any = |w_grant;
  assign dtr   = r_dtr;

  // Request fields are captured only at grant; the requester may change them freely afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ptr   <= IW'(NCH - 1);
      r_idx   <= '0;
      r_adr   <= '0;
      r_rw    <= 1'b0;
      r_io    <= 1'b0;
      r_dtw   <= '0;
      r_cnt   <= '0;
      r_dtr   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_any) begin
        r_idx <= w_idx;
        r_adr <= w_adr_ch[w_idx];
        r_rw  <= rw[w_idx];
        r_io  <= io[w_idx];
        r_dtw <= w_dtw_ch[w_idx];
        if (RR != 0) r_ptr <= w_idx;
      end
      if (r_state == LATCH) r_cnt <= 4'(WAIT);
      else if (r_state == DATA && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (r_state == DATA && r_cnt == 4'd0 && !r_rw) r_dtr <= din;
    end
  end

  always_comb begin
    w_state_next = r_state;
    dout         = '0;
    isout        = 1'b0;
    ale_n        = STROBE_IDLE;
    oe_n         = STROBE_IDLE;
    we_n         = STROBE_IDLE;
    pio          = 1'b0;
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_any) w_state_next = ADDR;
      end
      ADDR: begin
        isout        = 1'b1;
        dout         = r_adr[DAT_W-1:0];
        ale_n        = 1'b0;
        pio          = r_io;
        w_state_next = LATCH;
      end
      LATCH: begin
        isout        = 1'b1;
        dout         = r_adr[DAT_W-1:0];
        pio          = r_io;
        w_state_next = DATA;
      end
      DATA: begin
        pio = r_io;
        if (r_rw) begin
          isout = 1'b1;
          dout  = r_dtw;
          we_n  = 1'b0;
        end else begin
          oe_n = 1'b0;
        end
        if (r_cnt == 4'd0) w_state_next = RECOV;
      end
      RECOV: begin
        // Turnaround cycle: nobody drives the pins while ack is presented.
        pio          = r_io;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  generate
    if (ADR_W > DAT_W) begin : g_adr_hi
      assign adr_hi = busy ? r_adr[ADR_W-1:DAT_W] : '0;
    end else begin : g_adr_hi_tie
      assign adr_hi = '0;
    end
  endgenerate

endmodule
